// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID register and a 2-bit-counter BHT
// that predicts BNE branches in the same cycle the instruction is read.
// Latency: rom_addr is the current PC; IF/ID outputs are registered (1 cycle).
// Backpressure: stall holds PC and IF/ID; BHT training proceeds regardless.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   stall              hold PC and IF/ID register
//   branch_flag/addr   redirect request and target from ID
//   upd_valid/pc/taken resolved-BNE outcome used to train the BHT
//   rom_data           instruction read combinationally at rom_addr
//   rom_addr, rom_ce   fetch address and instruction memory enable
//   id_pc/inst/is_taken  registered fetch result to ID
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] rom_data,
  output logic [31:0] rom_addr,
  output logic        rom_ce,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_is_taken
);

  localparam int         BHT_N  = 1 << BHT_IDX_W;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic [31:0] pc_q, pc_d;
  logic        ce_q;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_taken_q, id_taken_d;
  logic [1:0]  bht_q [BHT_N];
  logic [1:0]  bht_d [BHT_N];

  logic [BHT_IDX_W-1:0] fetch_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 pred_taken;
  logic [31:0]          pc_plus4;
  logic [31:0]          pred_target;

  assign fetch_idx = pc_q[BHT_IDX_W+1:2];
  assign upd_idx   = upd_pc[BHT_IDX_W+1:2];
  assign pc_plus4  = pc_q + 32'd4;

  // Lookup reads the registered table, so a same-cycle update to the same
  // entry is invisible to this fetch and only affects the next one.
  assign pred_taken  = ce_q && (rom_data[31:26] == OP_BNE) && bht_q[fetch_idx][1];
  assign pred_target = pc_plus4 + {{14{rom_data[15]}}, rom_data[15:0], 2'b00};

  always_comb begin
    pc_d = pc_q;
    if (ce_q && !stall) begin
      if (branch_flag)     pc_d = branch_addr;
      else if (pred_taken) pc_d = pred_target;
      else                 pc_d = pc_plus4;
    end
  end

  // IF/ID is not flushed on redirect; ID squashes the delay slot itself.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_taken_d = id_taken_q;
    if (!stall) begin
      id_pc_d    = pc_q;
      id_inst_d  = ce_q ? rom_data : 32'h0000_0000;
      id_taken_d = pred_taken;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (upd_valid) begin
      if (upd_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      ce_q       <= 1'b0;
      id_pc_q    <= 32'h0000_0000;
      id_inst_q  <= 32'h0000_0000;
      id_taken_q <= 1'b0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      pc_q       <= pc_d;
      ce_q       <= 1'b1;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_taken_q <= id_taken_d;
      bht_q      <= bht_d;
    end
  end

  assign rom_addr    = pc_q;
  assign rom_ce      = ce_q;
  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_is_taken = id_taken_q;

  // Only the opcode and branch offset of the instruction, and only the index
  // bits of the update PC, matter here.
  logic unused_ok;
  assign unused_ok = ^{rom_data[25:16], upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] rom_data;
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_is_taken;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] BNE4 = 32'h1422_0004; // bne r1,r2,+4 words

  logic [31:0] rom [64];
  assign rom_data = rom[rom_addr[7:2]];

  if_stage #(.RESET_PC(32'h0000_0000), .BHT_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_addr(branch_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .rom_data(rom_data), .rom_addr(rom_addr), .rom_ce(rom_ce),
    .id_pc(id_pc), .id_inst(id_inst), .id_is_taken(id_is_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] a);
    branch_flag = 1'b1;
    branch_addr = a;
    step();
    branch_flag = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (rom_ce !== 1'b0) begin n_bad++; $display("FAIL reset_ce got %b want 0", rom_ce); end
    n_cmp++; if (rom_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", rom_addr); end
    n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
    n_cmp++; if (id_inst !== 32'h0) begin n_bad++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
    n_cmp++; if (id_is_taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken got %b want 0", id_is_taken); end
  endtask

  task automatic test_sequential();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (rom_ce !== 1'b0) begin n_bad++; $display("FAIL seq_ce_pre got %b want 0", rom_ce); end
    step();
    n_cmp++; if (rom_ce !== 1'b1) begin n_bad++; $display("FAIL seq_ce_rise got %b want 1", rom_ce); end
    n_cmp++; if (rom_addr !== 32'h0) begin n_bad++; $display("FAIL seq_addr0 got %h want 0", rom_addr); end
    n_cmp++; if (id_inst !== 32'h0) begin n_bad++; $display("FAIL seq_nop_inst got %h want 0", id_inst); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++; if (rom_addr !== 32'(4*k)) begin n_bad++; $display("FAIL seq_addr[%0d] got %h want %h", k, rom_addr, 32'(4*k)); end
      n_cmp++; if (id_pc !== 32'(4*(k-1))) begin n_bad++; $display("FAIL seq_id_pc[%0d] got %h want %h", k, id_pc, 32'(4*(k-1))); end
    end
  endtask

  task automatic test_bht_train();
    redirect(32'h20);
    n_cmp++; if (rom_addr !== 32'h20) begin n_bad++; $display("FAIL train_redir got %h want 20", rom_addr); end
    step();
    n_cmp++; if (rom_addr !== 32'h24) begin n_bad++; $display("FAIL train_nt_next got %h want 24", rom_addr); end
    n_cmp++; if (id_inst !== BNE4) begin n_bad++; $display("FAIL train_id_inst got %h want %h", id_inst, BNE4); end
    n_cmp++; if (id_is_taken !== 1'b0) begin n_bad++; $display("FAIL train_nt_taken got %b want 0", id_is_taken); end
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1;
    step();
    step();
    upd_valid = 1'b0;
    redirect(32'h20);
    step();
    n_cmp++; if (rom_addr !== 32'h34) begin n_bad++; $display("FAIL train_t_next got %h want 34", rom_addr); end
    n_cmp++; if (id_is_taken !== 1'b1) begin n_bad++; $display("FAIL train_t_taken got %b want 1", id_is_taken); end
    n_cmp++; if (id_pc !== 32'h20) begin n_bad++; $display("FAIL train_t_id_pc got %h want 20", id_pc); end
  endtask

  task automatic test_stall_branch();
    stall = 1'b1; branch_flag = 1'b1; branch_addr = 32'h100;
    step();
    n_cmp++; if (rom_addr !== 32'h34) begin n_bad++; $display("FAIL stall_pc got %h want 34", rom_addr); end
    n_cmp++; if (id_pc !== 32'h20) begin n_bad++; $display("FAIL stall_id_pc got %h want 20", id_pc); end
    n_cmp++; if (id_inst !== BNE4) begin n_bad++; $display("FAIL stall_id_inst got %h want %h", id_inst, BNE4); end
    n_cmp++; if (id_is_taken !== 1'b1) begin n_bad++; $display("FAIL stall_taken got %b want 1", id_is_taken); end
    stall = 1'b0;
    step();
    branch_flag = 1'b0;
    n_cmp++; if (rom_addr !== 32'h100) begin n_bad++; $display("FAIL unstall_redir got %h want 100", rom_addr); end
    n_cmp++; if (id_pc !== 32'h34) begin n_bad++; $display("FAIL unstall_id_pc got %h want 34", id_pc); end
    n_cmp++; if (id_is_taken !== 1'b0) begin n_bad++; $display("FAIL unstall_taken got %b want 0", id_is_taken); end
  endtask

  task automatic test_saturate();
    // Entry for 0x20 starts at 11: four decrements must stop at 00.
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b0;
    repeat (4) step();
    upd_valid = 1'b0;
    redirect(32'h20);
    step();
    n_cmp++; if (id_is_taken !== 1'b0) begin n_bad++; $display("FAIL sat_low_taken got %b want 0", id_is_taken); end
    n_cmp++; if (rom_addr !== 32'h24) begin n_bad++; $display("FAIL sat_low_next got %h want 24", rom_addr); end
    // Four increments while stalled: training continues, PC holds.
    stall = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1;
    repeat (4) step();
    stall = 1'b0; upd_valid = 1'b0;
    n_cmp++; if (rom_addr !== 32'h24) begin n_bad++; $display("FAIL sat_stall_hold got %h want 24", rom_addr); end
    redirect(32'h20);
    step();
    n_cmp++; if (id_is_taken !== 1'b1) begin n_bad++; $display("FAIL sat_high_taken got %b want 1", id_is_taken); end
    // 11 -> 10 still taken; 10 -> 01 not taken.
    upd_valid = 1'b1; upd_taken = 1'b0;
    step();
    upd_valid = 1'b0;
    redirect(32'h20);
    step();
    n_cmp++; if (rom_addr !== 32'h34) begin n_bad++; $display("FAIL sat_dec1_next got %h want 34", rom_addr); end
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    redirect(32'h20);
    step();
    n_cmp++; if (rom_addr !== 32'h24) begin n_bad++; $display("FAIL sat_dec2_next got %h want 24", rom_addr); end
  endtask

  task automatic test_same_cycle();
    // Entry is 01; update to 10 in the very cycle 0x20 is looked up.
    redirect(32'h20);
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1;
    step();
    upd_valid = 1'b0;
    n_cmp++; if (rom_addr !== 32'h24) begin n_bad++; $display("FAIL same_cycle_next got %h want 24", rom_addr); end
    n_cmp++; if (id_is_taken !== 1'b0) begin n_bad++; $display("FAIL same_cycle_taken got %b want 0", id_is_taken); end
    redirect(32'h20);
    step();
    n_cmp++; if (rom_addr !== 32'h34) begin n_bad++; $display("FAIL after_update_next got %h want 34", rom_addr); end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    step();
    n_cmp++; if (rom_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next got %h want 0", rom_addr); end
    n_cmp++; if (id_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_id_pc got %h want fffffffc", id_pc); end
  endtask

  task automatic test_reset_mid();
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    step();
    step();
    upd_valid = 1'b0;
    redirect(32'h40);
    branch_flag = 1'b1; branch_addr = 32'h80;
    upd_valid = 1'b1; upd_taken = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (rom_ce !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ce got %b want 0", rom_ce); end
    n_cmp++; if (rom_addr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_addr got %h want 0", rom_addr); end
    n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL mid_rst_id_pc got %h want 0", id_pc); end
    n_cmp++; if (id_inst !== 32'h0) begin n_bad++; $display("FAIL mid_rst_id_inst got %h want 0", id_inst); end
    n_cmp++; if (id_is_taken !== 1'b0) begin n_bad++; $display("FAIL mid_rst_taken got %b want 0", id_is_taken); end
    branch_flag = 1'b0; upd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    n_cmp++; if (rom_addr !== 32'h0 || rom_ce !== 1'b1) begin n_bad++; $display("FAIL restart got %h/%b want 0/1", rom_addr, rom_ce); end
    redirect(32'h40);
    step();
    n_cmp++; if (rom_addr !== 32'h44) begin n_bad++; $display("FAIL bht_cleared_next got %h want 44", rom_addr); end
    n_cmp++; if (id_is_taken !== 1'b0) begin n_bad++; $display("FAIL bht_cleared_taken got %b want 0", id_is_taken); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[8]  = BNE4; // 0x20
    rom[16] = BNE4; // 0x40
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; branch_addr = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    test_reset();
    test_sequential();
    test_bht_train();
    test_stall_branch();
    test_saturate();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BHT_IDX_W, default 4, meaning the branch-history-table index width (2^BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2]).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous and active-low (rst==0 resets).
REQ-005 SHALL have port stall, input, 1, meaning hold PC and the IF/ID register (from CTRL).
REQ-006 SHALL have port branch_flag, input, 1, meaning redirect request from ID.
REQ-007 SHALL have port branch_addr, input, 32, meaning the redirect target from ID.
REQ-008 SHALL have port upd_valid, input, 1, meaning a BNE resolved in ID this cycle.
REQ-009 SHALL have port upd_pc, input, 32, meaning the PC of the resolved BNE.
REQ-010 SHALL have port upd_taken, input, 1, meaning the actual outcome of that BNE.
REQ-011 SHALL have port rom_data, input, 32, meaning the instruction read combinationally at rom_addr.
REQ-012 SHALL have port rom_addr, output, 32, meaning the current fetch PC.
REQ-013 SHALL have port rom_ce, output, 1, meaning instruction-memory enable.
REQ-014 SHALL have port id_pc, output, 32, meaning the registered PC to ID.
REQ-015 SHALL have port id_inst, output, 32, meaning the registered instruction to ID.
REQ-016 SHALL have port id_is_taken, output, 1, meaning the registered prediction to ID (ID's isTaken).

Function
REQ-017 SHALL hold pc at RESET_PC while rom_ce==0; rom_ce SHALL rise on the first clk edge after reset release; rom_addr==pc at all times.
REQ-018 SHALL predict taken iff rom_ce==1, rom_data[31:26]==6'b000101 (BNE) and BHT[pc index] >= 2'b10; the prediction is combinational in the fetch cycle.
REQ-019 SHALL compute the predicted target as pc+4+{{14{rom_data[15]}},rom_data[15:0],2'b00}, modulo 2^32.
REQ-020 SHALL select next pc with priority: stall (hold) > branch_flag (branch_addr) > predicted taken (target) > pc+4; pc+4 wraps modulo 2^32.
REQ-021 SHALL, per cycle, on stall hold id_pc/id_inst/id_is_taken unchanged; else load pc, rom_data and the prediction; when rom_ce==0 load id_inst=0 (NOP), id_is_taken=0.
REQ-022 SHALL not null or flush the IF/ID register on branch_flag; delay-slot squashing is owned by ID.
REQ-023 SHALL, when upd_valid==1, update BHT[upd_pc index] as a 2-bit saturating counter: +1 if upd_taken (saturating at 11), -1 otherwise (saturating at 00).
REQ-024 SHALL apply BHT updates regardless of stall.
REQ-025 SHALL, on a same-cycle lookup and update of the same index, give the lookup the pre-update counter value.

Reset
REQ-026 SHALL, while rst==0, force pc=RESET_PC, rom_ce=0, id_pc=0, id_inst=0, id_is_taken=0, and every BHT entry to 2'b01 (weakly not taken), independent of clk.
REQ-027 SHALL, on assertion of rst mid-operation, abandon any in-flight redirect or pending update; no state survives.

Verification
REQ-028 SHALL cover: release rst, rom_data=NOPs -> rom_ce=1 after 1 edge, rom_addr 0,4,8,... per cycle; id_pc trails rom_addr by one cycle.
REQ-029 SHALL cover: BNE at pc 0x20 with imm 0x0004, BHT entry 01 -> not predicted, next pc 0x24; after two upd_valid/upd_taken=1 at 0x20 -> next fetch of 0x20 goes to 0x34 with id_is_taken=1.
REQ-030 SHALL cover: stall=1 and branch_flag=1 (branch_addr=0x100) together -> pc and IF/ID hold; stall drops with branch_flag=1 -> next pc 0x100.
REQ-031 SHALL cover: four upd_taken=0 updates to one entry -> counter saturates at 00; four upd_taken=1 updates -> saturates at 11, no wrap.
REQ-032 SHALL cover: pc=0xFFFF_FFFC, no branch -> next pc 0x0000_0000.
REQ-033 SHALL cover: rst pulsed low mid-fetch at pc 0x40 with a trained entry -> outputs zero immediately, BHT back to 01, fetch restarts at RESET_PC.
